// File: rtl/pic_pkg.sv
// Shared PIC definitions: in-service handshake states and vector width.
package pic_pkg;

  localparam int VEC_W = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_VEC = 1'b1
  } isr_state_e;

endpackage

// File: rtl/in_service_ctrl_if.sv
// Bus between the INTA/OCW2 control side and the in-service register.
interface in_service_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  import pic_pkg::*;

  localparam int IDX_W = $clog2(NUM_IRQ);

  logic               set_valid;
  logic [IDX_W-1:0]   set_idx;
  logic               vec_req;
  logic [VEC_W-1:0]   vec_base;
  logic               aeoi_en;
  logic               eoi_valid;
  logic               eoi_specific;
  logic [IDX_W-1:0]   eoi_idx;
  logic               eoi_rotate;

  logic [NUM_IRQ-1:0] isr;
  logic [IDX_W-1:0]   top_idx;
  logic               top_valid;
  logic               vec_valid;
  logic [VEC_W-1:0]   vec_data;
  logic               cleared_valid;
  logic [IDX_W-1:0]   cleared_idx;
  logic [IDX_W-1:0]   lowest_prio;
  logic               err;

  modport master (
    output set_valid, set_idx, vec_req, vec_base, aeoi_en,
           eoi_valid, eoi_specific, eoi_idx, eoi_rotate,
    input  isr, top_idx, top_valid, vec_valid, vec_data,
           cleared_valid, cleared_idx, lowest_prio, err
  );

  modport slave (
    input  set_valid, set_idx, vec_req, vec_base, aeoi_en,
           eoi_valid, eoi_specific, eoi_idx, eoi_rotate,
    output isr, top_idx, top_valid, vec_valid, vec_data,
           cleared_valid, cleared_idx, lowest_prio, err
  );

endinterface

// File: rtl/prio_scan.sv
// Circular find-first: first set bit of vec searching upward from start, wrapping.
module prio_scan #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] pos;

  // Walk from the farthest offset back to start so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = start + W'(i);
      if (vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/in_service_ctrl.sv
// PIC in-service register with two-step INTA handshake, AEOI/EOI clearing and error flag.
// Define ISR_ROTATE_EN to make lowest_prio a register updated by rotating EOIs.
module in_service_ctrl
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic              clk,
  input  logic              reset,
  in_service_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_IRQ);

  isr_state_e         state_q, state_d;
  logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic               vec_valid_q, vec_valid_d;
  logic [VEC_W-1:0]   vec_data_q, vec_data_d;
  logic               cleared_valid_q, cleared_valid_d;
  logic [IDX_W-1:0]   cleared_idx_q, cleared_idx_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   lowest_prio;

  logic [IDX_W-1:0]   top_idx;
  logic               top_valid;
  logic [IDX_W-1:0]   eoi_tgt;
  logic               eoi_hit;

  prio_scan #(.N(NUM_IRQ)) u_scan (
    .vec   (isr_q),
    .start (lowest_prio + IDX_W'(1)),
    .idx   (top_idx),
    .found (top_valid)
  );

`ifdef ISR_ROTATE_EN
  logic [IDX_W-1:0] lowest_prio_q, lowest_prio_d;

  always_comb begin
    lowest_prio_d = lowest_prio_q;
    if (bus.eoi_rotate && cleared_valid_d) lowest_prio_d = cleared_idx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) lowest_prio_q <= IDX_W'(NUM_IRQ - 1);
    else       lowest_prio_q <= lowest_prio_d;
  end

  assign lowest_prio = lowest_prio_q;

  logic unused_base;
  assign unused_base = &bus.vec_base[IDX_W-1:0];
`else
  assign lowest_prio = IDX_W'(NUM_IRQ - 1);

  logic unused_inputs;
  assign unused_inputs = &{bus.eoi_rotate, bus.vec_base[IDX_W-1:0]};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d         = state_q;
    cap_idx_d       = cap_idx_q;
    isr_d           = isr_q;
    vec_valid_d     = 1'b0;
    vec_data_d      = vec_data_q;
    cleared_valid_d = 1'b0;
    cleared_idx_d   = cleared_idx_q;
    err_d           = err_q;

    // Manual EOI looks at the pre-set isr; a zero target bit means no clear and no pulse.
    eoi_tgt = bus.eoi_specific ? bus.eoi_idx : top_idx;
    eoi_hit = bus.eoi_valid && isr_q[eoi_tgt];
    if (eoi_hit) begin
      isr_d[eoi_tgt]  = 1'b0;
      cleared_valid_d = 1'b1;
      cleared_idx_d   = eoi_tgt;
    end

    case (state_q)
      IDLE: begin
        if (bus.vec_req) err_d = 1'b1;
        if (bus.set_valid) begin
          if (isr_q[bus.set_idx]) err_d = 1'b1;
          cap_idx_d = bus.set_idx;
          state_d   = WAIT_VEC;
        end
      end
      WAIT_VEC: begin
        if (bus.set_valid) err_d = 1'b1;
        if (bus.vec_req) begin
          vec_valid_d = 1'b1;
          vec_data_d  = {bus.vec_base[VEC_W-1:IDX_W], cap_idx_q};
          state_d     = IDLE;
          // AEOI overrides the cleared_* report of a same-cycle manual EOI.
          if (bus.aeoi_en && isr_q[cap_idx_q]) begin
            isr_d[cap_idx_q] = 1'b0;
            cleared_valid_d  = 1'b1;
            cleared_idx_d    = cap_idx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The grant is applied after all clears so a same-bit set survives.
    if (state_q == IDLE && bus.set_valid) isr_d[bus.set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q         <= IDLE;
      cap_idx_q       <= '0;
      isr_q           <= '0;
      vec_valid_q     <= 1'b0;
      vec_data_q      <= '0;
      cleared_valid_q <= 1'b0;
      cleared_idx_q   <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cap_idx_q       <= cap_idx_d;
      isr_q           <= isr_d;
      vec_valid_q     <= vec_valid_d;
      vec_data_q      <= vec_data_d;
      cleared_valid_q <= cleared_valid_d;
      cleared_idx_q   <= cleared_idx_d;
      err_q           <= err_d;
    end
  end

  assign bus.isr           = isr_q;
  assign bus.top_idx       = top_idx;
  assign bus.top_valid     = top_valid;
  assign bus.vec_valid     = vec_valid_q;
  assign bus.vec_data      = vec_data_q;
  assign bus.cleared_valid = cleared_valid_q;
  assign bus.cleared_idx   = cleared_idx_q;
  assign bus.lowest_prio   = lowest_prio;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Bench for in_service_ctrl: directed cases plus random traffic against a behavioural model.
module tb_in_service_ctrl;

  localparam int N = 8;

  logic clk;
  logic reset;

  in_service_ctrl_if #(.NUM_IRQ(8))  bus8 ();
  in_service_ctrl_if #(.NUM_IRQ(16)) bus16 ();

  in_service_ctrl #(.NUM_IRQ(8))  dut   (.clk(clk), .reset(reset), .bus(bus8));
  in_service_ctrl #(.NUM_IRQ(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 8-channel instance ----------------
  logic [7:0] m_isr;
  int         m_low;
  bit         m_busy;
  int         m_cap;
  bit         m_vv;
  logic [7:0] m_vdata;
  bit         m_cv;
  int         m_cidx;
  bit         m_err;
  bit         m_ready = 1'b0;

  function automatic int model_top(input logic [7:0] v, input int low);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (low + k) % N;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [7:0] pre, nxt;
    bit busy_n, vv, cv, err_n;
    int cap_n, cidx_n, low_n, tgt;
    logic [7:0] vdata_n;
    if (reset) begin
      m_isr <= '0; m_low <= N - 1; m_busy <= 0; m_cap <= 0;
      m_vv <= 0; m_vdata <= '0; m_cv <= 0; m_cidx <= 0; m_err <= 0; m_ready <= 1;
      return;
    end
    pre = m_isr; nxt = m_isr; busy_n = m_busy; cap_n = m_cap;
    vv = 0; vdata_n = m_vdata; cv = 0; cidx_n = m_cidx; err_n = m_err; low_n = m_low;
    if (bus8.eoi_valid && pre != 0) begin
      tgt = bus8.eoi_specific ? int'(bus8.eoi_idx) : model_top(pre, m_low);
      if (pre[tgt]) begin nxt[tgt] = 0; cv = 1; cidx_n = tgt; end
    end
    if (m_busy) begin
      if (bus8.set_valid) err_n = 1;
      if (bus8.vec_req) begin
        vv = 1; busy_n = 0;
        vdata_n = (bus8.vec_base & ~8'(N - 1)) | 8'(m_cap);
        if (bus8.aeoi_en && pre[m_cap]) begin nxt[m_cap] = 0; cv = 1; cidx_n = m_cap; end
      end
    end else begin
      if (bus8.vec_req) err_n = 1;
      if (bus8.set_valid) begin
        if (pre[bus8.set_idx]) err_n = 1;
        busy_n = 1; cap_n = int'(bus8.set_idx);
      end
    end
    if (!m_busy && bus8.set_valid) nxt[bus8.set_idx] = 1;
`ifdef ISR_ROTATE_EN
    if (bus8.eoi_rotate && cv) low_n = cidx_n;
`endif
    m_isr <= nxt; m_low <= low_n; m_busy <= busy_n; m_cap <= cap_n;
    m_vv <= vv; m_vdata <= vdata_n; m_cv <= cv; m_cidx <= cidx_n; m_err <= err_n;
  endtask

  always @(posedge clk) model_step();

  // One compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_ready) begin
      check("isr",           bus8.isr,           m_isr);
      check("top_idx",       bus8.top_idx,       model_top(m_isr, m_low));
      check("top_valid",     bus8.top_valid,     m_isr != 0);
      check("vec_valid",     bus8.vec_valid,     m_vv);
      check("vec_data",      bus8.vec_data,      m_vdata);
      check("cleared_valid", bus8.cleared_valid, m_cv);
      check("cleared_idx",   bus8.cleared_idx,   m_cidx);
      check("lowest_prio",   bus8.lowest_prio,   m_low);
      check("err",           bus8.err,           m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle8();
    bus8.set_valid = 0; bus8.set_idx = '0; bus8.vec_req = 0;
    bus8.eoi_valid = 0; bus8.eoi_specific = 0; bus8.eoi_idx = '0; bus8.eoi_rotate = 0;
  endtask

  task automatic idle16();
    bus16.set_valid = 0; bus16.set_idx = '0; bus16.vec_req = 0; bus16.vec_base = 8'hA0;
    bus16.aeoi_en = 0; bus16.eoi_valid = 0; bus16.eoi_specific = 0; bus16.eoi_idx = '0;
    bus16.eoi_rotate = 0;
  endtask

  task automatic do_set(input int idx);
    bus8.set_valid = 1; bus8.set_idx = 3'(idx); tick(); idle8();
  endtask

  task automatic do_vec();
    bus8.vec_req = 1; tick(); idle8();
  endtask

  task automatic do_eoi(input bit spec, input int idx, input bit rot);
    bus8.eoi_valid = 1; bus8.eoi_specific = spec; bus8.eoi_idx = 3'(idx); bus8.eoi_rotate = rot;
    tick(); idle8();
  endtask

  task automatic pulse_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    idle8(); idle16();
    bus8.vec_base = 8'h40; bus8.aeoi_en = 0;
    reset = 1;
    tick(); tick();
    reset = 0;

    check("rst_isr", bus8.isr, 8'h00);
    check("rst_lowest", bus8.lowest_prio, 7);
    check("rst_err", bus8.err, 0);
    check("rst_vec_data", bus8.vec_data, 8'h00);

    // Case 1: grant IR3, vector 0x43
    do_set(3);
    check("t1_isr", bus8.isr, 8'h08);
    check("t1_model_isr", m_isr, 8'h08);
    bus8.vec_req = 1; tick(); idle8();
    check("t1_vec_valid", bus8.vec_valid, 1);
    check("t1_vec_data", bus8.vec_data, 8'h43);
    tick();
    check("t1_vec_pulse_end", bus8.vec_valid, 0);
    do_eoi(1, 3, 0);
    check("t1_eoi_clear", bus8.cleared_valid, 1);
    check("t1_isr_zero", bus8.isr, 8'h00);

    // Case 2: AEOI on IR5
    bus8.aeoi_en = 1;
    bus8.vec_base = 8'h40;
    do_set(5);
    do_vec();
    check("t2_vec_data", bus8.vec_data, 8'h45);
    check("t2_isr", bus8.isr, 8'h00);
    check("t2_cleared_valid", bus8.cleared_valid, 1);
    check("t2_cleared_idx", bus8.cleared_idx, 5);
    bus8.aeoi_en = 0;

    // Case 3: isr=0x24, non-specific then specific EOI
    do_set(2); do_vec(); do_set(5); do_vec();
    check("t3_isr", bus8.isr, 8'h24);
    do_eoi(0, 0, 0);
    check("t3_ns_eoi", bus8.isr, 8'h20);
    check("t3_ns_idx", bus8.cleared_idx, 2);
    do_eoi(1, 5, 0);
    check("t3_sp_eoi", bus8.isr, 8'h00);

    // Case 4: rotating non-specific EOI on isr=0x11
    do_set(0); do_vec(); do_set(4); do_vec();
    check("t4_isr", bus8.isr, 8'h11);
    do_eoi(0, 0, 1);
    check("t4_isr_after", bus8.isr, 8'h10);
    do_set(0); do_vec();
`ifdef ISR_ROTATE_EN
    check("t4_lowest", bus8.lowest_prio, 0);
    check("t4_top", bus8.top_idx, 4);
`else
    check("t4_lowest", bus8.lowest_prio, 7);
    check("t4_top", bus8.top_idx, 0);
`endif
    do_eoi(1, 0, 0); do_eoi(1, 4, 0);
    check("t4_cleanup", bus8.isr, 8'h00);

    // Case 5: set during WAIT_VEC, then reset mid-handshake
    do_set(1);
    do_set(6);
    check("t5_err", bus8.err, 1);
    check("t5_isr", bus8.isr, 8'h02);
    reset = 1; bus8.vec_req = 1; tick(); idle8(); reset = 0;
    check("t5_rst_vec", bus8.vec_valid, 0);
    check("t5_rst_isr", bus8.isr, 8'h00);
    check("t5_rst_err", bus8.err, 0);
    tick();
    check("t5_no_late_vec", bus8.vec_valid, 0);
    do_vec();
    check("t5_idle_vec_err", bus8.err, 1);
    check("t5_idle_no_vec", bus8.vec_valid, 0);

    // Case 6: 16-channel instance
    bus16.set_valid = 1; bus16.set_idx = 4'd15; tick(); idle16();
    check("t6_isr16", bus16.isr, 16'h8000);
    bus16.vec_req = 1; tick(); idle16();
    check("t6_vec_valid16", bus16.vec_valid, 1);
    check("t6_vec_data16", bus16.vec_data, 8'hAF);
    bus16.eoi_valid = 1; bus16.eoi_specific = 1; bus16.eoi_idx = 4'd15; tick(); idle16();
    check("t6_clear16", bus16.isr, 16'h0000);
    bus16.eoi_valid = 1; tick(); idle16();
    check("t6_empty_eoi16", bus16.cleared_valid, 0);

    pulse_reset();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) bus8.aeoi_en = 1'($urandom_range(0, 1));
      if (c % 50 == 0) bus8.vec_base = 8'($urandom);
      bus8.set_valid    = ($urandom_range(0, 2) == 0);
      bus8.set_idx      = 3'($urandom);
      bus8.vec_req      = ($urandom_range(0, 2) == 0);
      bus8.eoi_valid    = ($urandom_range(0, 3) == 0);
      bus8.eoi_specific = 1'($urandom_range(0, 1));
      bus8.eoi_idx      = 3'($urandom);
      bus8.eoi_rotate   = 1'($urandom_range(0, 1));
      reset             = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; idle8();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
